stage_4_flush_ctrl: RTL

- Sequencer that drives the control inputs of the stage-4 carry/final-bits datapath.
- Holds off the datapath after reset, marks the first symbol, and runs the two-cycle end-of-frame flush: final-bits capture, then final-bits emit.
- Waits for the last-output flag, tallies emitted bytes per frame, and reports done or timeout.
- Sits between the frame-level top control and the stage-4 instance.

---
 rtl/stage_4_flush_ctrl_pkg.sv | 18 +
 rtl/stage_4_flush_ctrl_byte_tally_sat.sv | 25 ++
 rtl/stage_4_flush_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/stage_4_flush_ctrl_pkg.sv
// Shared definitions for the stage-4 flush controller.
//   state_t              : controller FSM state encoding (3 bits)
//   MAX_BYTES_PER_CYCLE  : largest legal byte count the stage-4 output can flag
package stage_4_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WARMUP  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_EMIT    = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [2:0] MAX_BYTES_PER_CYCLE = 3'd5;

endpackage

// File: rtl/stage_4_flush_ctrl_byte_tally_sat.sv
// Saturating per-frame byte accumulator (combinational next value).
//   count       in  current byte count
//   carry_flag  in  byte-count flag from stage 4; values above the legal
//                   maximum are treated as zero
//   count_next  out count + carry_flag, clamped at all-ones
module byte_tally_sat
    import stage_4_flush_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 24
) (
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [2:0]             carry_flag,
    output logic [COUNT_WIDTH-1:0] count_next
);

    logic [2:0]           add;
    logic [COUNT_WIDTH:0] sum;

    always_comb begin
        add        = (carry_flag <= MAX_BYTES_PER_CYCLE) ? carry_flag : 3'd0;
        sum        = {1'b0, count} + (COUNT_WIDTH + 1)'(add);
        count_next = sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
    end

endmodule

// File: rtl/stage_4_flush_ctrl.sv
// Sequencer for the stage-4 carry/final-bits datapath control inputs.
// Holds stage 4 off after reset, marks the first symbol of a frame, runs the
// two-cycle end-of-frame flush (capture, then emit), waits for the last-output
// flag and reports done or timeout while tallying emitted bytes.
//   clk, reset          clock, asynchronous active-high reset
//   in_valid, in_end    symbol presented to stage 4 / last symbol of frame
//   in_carry_flag       stage-4 output byte count (0..5 valid)
//   in_flag_last        stage-4 last-output flag
//   out_ready           symbol accepted this cycle
//   out_flag_first      stage-4 flag_first
//   out_final_flag_2_3  stage-4 final-bits capture enable
//   out_final_flag      stage-4 final mux select
//   out_busy            frame in progress
//   out_done            frame finished normally (one-cycle pulse)
//   out_timeout         sticky: last-output flag never arrived
//   out_byte_count      bytes emitted in the current/last frame
module stage_4_flush_ctrl
    import stage_4_flush_ctrl_pkg::*;
#(
    parameter int WARMUP_CYCLES = 3,
    parameter int DRAIN_TIMEOUT = 15,
    parameter int COUNT_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_end,
    input  logic [2:0]             in_carry_flag,
    input  logic                   in_flag_last,
    output logic                   out_ready,
    output logic                   out_flag_first,
    output logic                   out_final_flag_2_3,
    output logic                   out_final_flag,
    output logic                   out_busy,
    output logic                   out_done,
    output logic                   out_timeout,
    output logic [COUNT_WIDTH-1:0] out_byte_count
);

    localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    state_t                 state, state_n;
    logic [WW-1:0]          warm_cnt, warm_cnt_n;
    logic [DW-1:0]          drain_cnt, drain_cnt_n;
    logic                   end_pend, end_pend_n;
    logic                   accept;
    logic                   first_d, done_d, timeout_set, clear_cnt;
    logic                   ready_d, busy_d;
    logic [COUNT_WIDTH-1:0] tally_next;

    assign accept = out_ready & in_valid;

    byte_tally_sat #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_tally (
        .count      (out_byte_count),
        .carry_flag (in_carry_flag),
        .count_next (tally_next)
    );

    always_comb begin
        state_n     = state;
        warm_cnt_n  = warm_cnt;
        drain_cnt_n = drain_cnt;
        end_pend_n  = end_pend;
        first_d     = 1'b0;
        done_d      = 1'b0;
        timeout_set = 1'b0;
        clear_cnt   = 1'b0;
        case (state)
            ST_WARMUP: begin
                if (warm_cnt == WARM_LAST) begin
                    state_n    = ST_IDLE;
                    warm_cnt_n = '0;
                end else begin
                    warm_cnt_n = warm_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    first_d    = 1'b1;
                    clear_cnt  = 1'b1;
                    state_n    = ST_RUN;
                    // A single-symbol frame still spends one cycle in RUN so
                    // the first-symbol mark and the capture enable land on
                    // consecutive cycles instead of overlapping.
                    end_pend_n = in_end;
                end
            end
            ST_RUN: begin
                if (end_pend) begin
                    state_n    = ST_CAPTURE;
                    end_pend_n = 1'b0;
                end else if (accept && in_end) begin
                    state_n = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_n = ST_EMIT;
            ST_EMIT: begin
                drain_cnt_n = DRAIN_LOAD;
                state_n     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (in_flag_last) begin
                    done_d  = 1'b1;
                    state_n = ST_DONE;
                end else if (drain_cnt <= DRAIN_ONE) begin
                    drain_cnt_n = '0;
                    timeout_set = 1'b1;
                    state_n     = ST_DONE;
                end else begin
                    drain_cnt_n = drain_cnt - 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_WARMUP;
        endcase

        // Outputs are registered from the next state so they line up with it.
        ready_d = (state_n == ST_IDLE) || ((state_n == ST_RUN) && !end_pend_n);
        busy_d  = (state_n == ST_RUN) || (state_n == ST_CAPTURE) ||
                  (state_n == ST_EMIT) || (state_n == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_WARMUP;
            warm_cnt           <= '0;
            drain_cnt          <= '0;
            end_pend           <= 1'b0;
            out_ready          <= 1'b0;
            out_flag_first     <= 1'b0;
            out_final_flag_2_3 <= 1'b0;
            out_final_flag     <= 1'b0;
            out_busy           <= 1'b0;
            out_done           <= 1'b0;
            out_timeout        <= 1'b0;
            out_byte_count     <= '0;
        end else begin
            state              <= state_n;
            warm_cnt           <= warm_cnt_n;
            drain_cnt          <= drain_cnt_n;
            end_pend           <= end_pend_n;
            out_ready          <= ready_d;
            out_flag_first     <= first_d;
            out_final_flag_2_3 <= (state_n == ST_CAPTURE);
            out_final_flag     <= (state_n == ST_EMIT);
            out_busy           <= busy_d;
            out_done           <= done_d;
            out_timeout        <= out_timeout | timeout_set;
            if (state != ST_WARMUP) begin
                // The first symbol starts a new frame; any byte flag seen on
                // that cycle still belongs to the previous frame's tail.
                if (clear_cnt) out_byte_count <= '0;
                else           out_byte_count <= tally_next;
            end
        end
    end

endmodule
